// File: rtl/parity_check_pipe.sv
// Multi-channel even/odd parity checker: a two-stage registered pipeline with a per-channel
// error flag, a sticky error flag and a saturating error-word counter. The optional
// threshold interrupt is built only when PARITY_IRQ_EN is defined; otherwise irq_o is tied 0.
module parity_check_pipe #(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 1,
  parameter int CNT_W      = 8,
  parameter int IRQ_THRESH = 4
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n,
  input  logic                     in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_par,
  input  logic                     odd_mode,
  input  logic                     clr_i,
  output logic                     out_valid,
  output logic [NUM_CH-1:0]        out_err,
  output logic                     err_sticky,
  output logic [CNT_W-1:0]         err_cnt,
  output logic                     irq_o
);

  if (DATA_W < 2 || NUM_CH < 1 || CNT_W < 2 || IRQ_THRESH < 0) begin : g_param_err
    $error("parity_check_pipe: illegal parameter value");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                     v1;
  logic [NUM_CH*DATA_W-1:0] data_s1;
  logic [NUM_CH-1:0]        par_s1;
  logic                     odd_s1;
  logic [NUM_CH-1:0]        err;
  logic                     err_word;
  logic [CNT_W-1:0]         cnt_next;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      v1 <= 1'b0;
    end else begin
      v1 <= in_valid;
    end
  end

  // Payload registers hold their value while idle to avoid needless toggling.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      data_s1 <= '0;
      par_s1  <= '0;
      odd_s1  <= 1'b0;
    end else if (in_valid) begin
      data_s1 <= in_data;
      par_s1  <= in_par;
      odd_s1  <= odd_mode;
    end
  end

  always_comb begin
    err = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      err[c] = (^{data_s1[c*DATA_W +: DATA_W], par_s1[c]}) ^ odd_s1;
    end
  end

  assign err_word = v1 & (|err);

  // A clear wins over a coincident error word.
  always_comb begin
    cnt_next = err_cnt;
    if (clr_i) begin
      cnt_next = '0;
    end else if (err_word && (err_cnt != CNT_MAX)) begin
      cnt_next = err_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      out_valid  <= 1'b0;
      out_err    <= '0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      out_valid  <= v1;
      out_err    <= v1 ? err : '0;
      err_cnt    <= cnt_next;
      err_sticky <= clr_i ? 1'b0 : (err_sticky | err_word);
    end
  end

`ifdef PARITY_IRQ_EN
  localparam logic [CNT_W-1:0] IRQ_LVL = CNT_W'(IRQ_THRESH);

  logic irq_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      irq_q <= 1'b0;
    end else if (clr_i) begin
      irq_q <= 1'b0;
    end else if (cnt_next >= IRQ_LVL) begin
      irq_q <= 1'b1;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_parity_check_pipe.sv
// Bench for parity_check_pipe with four byte channels and a 4-bit counter: a latency
// scoreboard model compared every cycle, plus hand-computed checks on directed words.
module tb_parity_check_pipe;
  localparam int DW = 8;
  localparam int NC = 4;
  localparam int CW = 4;
  localparam int TH = 4;
`ifdef PARITY_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic [NC*DW-1:0] in_data = '0;
  logic [NC-1:0]  in_par = '0;
  logic           odd_mode = 1'b0;
  logic           clr_i = 1'b0;
  logic           out_valid;
  logic [NC-1:0]  out_err;
  logic           err_sticky;
  logic [CW-1:0]  err_cnt;
  logic           irq_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  parity_check_pipe #(.DATA_W(DW), .NUM_CH(NC), .CNT_W(CW), .IRQ_THRESH(TH)) dut (
    .wb_clk_i  (clk),
    .wb_rst_n  (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_par    (in_par),
    .odd_mode  (odd_mode),
    .clr_i     (clr_i),
    .out_valid (out_valid),
    .out_err   (out_err),
    .err_sticky(err_sticky),
    .err_cnt   (err_cnt),
    .irq_o     (irq_o)
  );

  typedef struct {
    int            due;
    logic [NC-1:0] err;
  } exp_t;

  exp_t          pend[$];
  exp_t          new_e;
  exp_t          old_e;
  int            cyc = 0;
  logic          exp_valid = 1'b0;
  logic [NC-1:0] exp_err = '0;
  logic          exp_sticky = 1'b0;
  int            exp_cnt = 0;
  logic          exp_irq = 1'b0;
  bit            check_en = 1'b0;

  // Parity rule: even mode flags an odd ones count, odd mode flags an even ones count.
  function automatic logic [NC-1:0] ref_err(input logic [NC*DW-1:0] d, input logic [NC-1:0] p,
                                            input logic odd);
    logic [NC-1:0] e;
    logic [DW-1:0] w;
    int            ones;
    e = '0;
    for (int c = 0; c < NC; c++) begin
      w    = d[c*DW +: DW];
      ones = $countones(w) + int'(p[c]);
      e[c] = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted word is due one edge after the edge that sampled it.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      pend.delete();
      exp_valid  = 1'b0;
      exp_err    = '0;
      exp_sticky = 1'b0;
      exp_cnt    = 0;
      exp_irq    = 1'b0;
    end else begin
      cyc++;
      exp_valid = 1'b0;
      exp_err   = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        old_e     = pend.pop_front();
        exp_valid = 1'b1;
        exp_err   = old_e.err;
      end
      if (clr_i) begin
        exp_cnt    = 0;
        exp_sticky = 1'b0;
        exp_irq    = 1'b0;
      end else if (exp_valid && (|exp_err)) begin
        exp_sticky = 1'b1;
        if (exp_cnt < 2**CW - 1) exp_cnt++;
      end
      if (IRQ_EN && !clr_i && exp_cnt >= TH) exp_irq = 1'b1;
      if (in_valid) begin
        new_e.due = cyc + 1;
        new_e.err = ref_err(in_data, in_par, odd_mode);
        pend.push_back(new_e);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      check("out_err", 32'(out_err), 32'(exp_err));
      check("err_sticky", 32'(err_sticky), 32'(exp_sticky));
      check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
      check("irq_o", 32'(irq_o), 32'(exp_irq));
    end
  end

  task automatic drive(input logic v, input logic [NC*DW-1:0] d, input logic [NC-1:0] p,
                       input logic odd, input logic clr);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = d;
    in_par   = p;
    odd_mode = odd;
    clr_i    = clr;
  endtask

  // One isolated word; clr (if set) lands on the edge that loads its result.
  task automatic word_and_check(input string name, input logic [NC*DW-1:0] d,
                                input logic [NC-1:0] p, input logic odd, input logic clr,
                                input logic [NC-1:0] e_err, input int e_cnt,
                                input logic e_sticky, input logic e_irq);
    drive(1'b1, d, p, odd, 1'b0);
    drive(1'b0, '0, '0, odd, clr);
    drive(1'b0, '0, '0, odd, 1'b0);
    @(negedge clk);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_err"}, 32'(out_err), 32'(e_err));
    check({name, "_cnt"}, 32'(err_cnt), 32'(e_cnt));
    check({name, "_sticky"}, 32'(err_sticky), 32'(e_sticky));
    check({name, "_irq"}, 32'(irq_o), 32'(e_irq));
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    in_par   = '1;
    repeat (3) @(posedge clk);
    check_en = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_err", 32'(out_err), 32'd0);
    check("rst_cnt", 32'(err_cnt), 32'd0);
    check("rst_sticky", 32'(err_sticky), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_cnt", 32'(err_cnt), 32'd0);

    word_and_check("even_good", 32'h0000_00A5, 4'b0000, 1'b0, 1'b0, 4'b0000, 0, 1'b0, 1'b0);
    word_and_check("even_bad", 32'h0000_00A4, 4'b0000, 1'b0, 1'b0, 4'b0001, 1, 1'b1, 1'b0);
    word_and_check("odd_good", 32'h0000_00A5, 4'b1111, 1'b1, 1'b0, 4'b0000, 1, 1'b1, 1'b0);
    word_and_check("odd_bad", 32'h0000_00A5, 4'b1110, 1'b1, 1'b0, 4'b0001, 2, 1'b1, 1'b0);

    // Back-to-back words with odd_mode flipping: bad(odd), good(even), good(odd).
    drive(1'b1, 32'h0000_00A5, 4'b1110, 1'b1, 1'b0);
    drive(1'b1, 32'h0000_00A5, 4'b0000, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_00A4, 4'b1110, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check("flip_cnt", 32'(err_cnt), 32'd3);

    word_and_check("clr_coinc", 32'h0000_00A4, 4'b0000, 1'b0, 1'b1, 4'b0001, 0, 1'b0, 1'b0);

    for (int i = 1; i <= 4; i++) begin
      word_and_check("irq_ramp", 32'h0000_00A4, 4'b0000, 1'b0, 1'b0, 4'b0001, i, 1'b1,
                     IRQ_EN && (i >= TH));
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check("clr_cnt", 32'(err_cnt), 32'd0);
    check("clr_sticky", 32'(err_sticky), 32'd0);
    check("clr_irq", 32'(irq_o), 32'd0);

    word_and_check("ch2_bad", 32'h0001_0000, 4'b0000, 1'b0, 1'b0, 4'b0100, 1, 1'b1, 1'b0);

    for (int i = 0; i < 100; i++) begin
      drive(1'b1, (i % 2) ? 32'h0101_0101 : 32'h0000_00A4, 4'b0000, 1'b0, 1'b0);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check("sat_cnt", 32'(err_cnt), 32'd15);
    check("sat_sticky", 32'(err_sticky), 32'd1);
    check("sat_irq", 32'(irq_o), 32'(IRQ_EN));

    drive(1'b1, 32'h0000_00A4, 4'b0000, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_00A4, 4'b0000, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_cnt", 32'(err_cnt), 32'd0);
    check("midrst_irq", 32'(irq_o), 32'd0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_flush", 32'(out_valid), 32'd0);
    end

    word_and_check("post_rst", 32'h0000_00A4, 4'b0000, 1'b0, 1'b0, 4'b0001, 1, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
